// File: rtl/proc_pkg.sv
// Shared definitions for the processor interrupt path: FSM encoding, vector
// defaults and the fixed-priority encoder used for arbitration.
package proc_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_REQ     = 2'd1;
    localparam state_t ST_SERVICE = 2'd2;

    localparam logic [7:0]  DEF_VEC_BASE   = 8'hF0;
    localparam int unsigned DEF_VEC_STRIDE = 2;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } penc_t;

    // Lowest set index wins; up to 8 channels, callers zero-pad narrower vectors.
    function automatic penc_t pri_enc(input logic [7:0] v);
        penc_t r;
        r.valid = 1'b0;
        r.idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                r.valid = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge detector and pending latch for the interrupt lines.
// A new edge beats a clear arriving on the same cycle.
module irq_edge_latch #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_irq,
    input  logic [W-1:0] i_clr,
    output logic [W-1:0] o_pending
);

    logic [W-1:0] r_prev;
    logic [W-1:0] r_pending;
    logic [W-1:0] w_rise;

    assign w_rise = i_irq & ~r_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev    <= '0;
            r_pending <= '0;
        end else begin
            r_prev    <= i_irq;
            r_pending <= (r_pending & ~i_clr) | w_rise;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/irq_ctrl.sv
// Maskable fixed-priority interrupt controller with req/ack handshake and
// vectored dispatch. Define IRQ_NESTING_EN to allow higher-priority preemption.
module irq_ctrl
    import proc_pkg::*;
#(
    parameter int                IRQ_N      = 4,
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(DEF_VEC_BASE),
    parameter int unsigned       VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IRQ_N-1:0]  irq,
    input  logic              mask_we,
    input  logic [IRQ_N-1:0]  mask_din,
    output logic              int_req,
    input  logic              int_ack,
    output logic [ADDR_W-1:0] vector,
    input  logic              iret,
    output logic [IRQ_N-1:0]  in_service,
    output logic [IRQ_N-1:0]  pending
);

    state_t              r_state;
    logic [IRQ_N-1:0]    r_mask;
    logic [IRQ_N-1:0]    r_in_service;
    logic [2:0]          r_win;
    logic                r_int_req;
    logic [ADDR_W-1:0]   r_vector;

    logic [IRQ_N-1:0]    w_pending;
    logic [IRQ_N-1:0]    w_clr;
    logic [IRQ_N-1:0]    w_win_oh;
    logic [ADDR_W-1:0]   w_vec;
    logic                w_ack;
    logic                w_mask_drop;
    penc_t               w_win;

    irq_edge_latch #(.W(IRQ_N)) u_latch (
        .clk       (clk),
        .reset     (reset),
        .i_irq     (irq),
        .i_clr     (w_clr),
        .o_pending (w_pending)
    );

    assign w_win    = pri_enc(8'(w_pending & r_mask));
    assign w_vec    = VEC_BASE + ADDR_W'(w_win.idx) * ADDR_W'(VEC_STRIDE);
    assign w_win_oh = IRQ_N'(1) << r_win;
    assign w_ack    = (r_state == ST_REQ) && int_ack;
    assign w_clr    = w_ack ? w_win_oh : '0;
    // A mask write that disables the requesting channel withdraws the request.
    assign w_mask_drop = mask_we && ((mask_din & w_win_oh) == '0);

`ifdef IRQ_NESTING_EN
    penc_t            w_isr;
    logic [IRQ_N-1:0] w_isr_rest;
    logic             w_preempt;

    assign w_isr      = pri_enc(8'(r_in_service));
    assign w_isr_rest = r_in_service & (r_in_service - IRQ_N'(1));
    assign w_preempt  = w_win.valid && (!w_isr.valid || (w_win.idx < w_isr.idx));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask <= '0;
        end else if (mask_we) begin
            r_mask <= mask_din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_in_service <= '0;
            r_win        <= 3'd0;
            r_int_req    <= 1'b0;
            r_vector     <= VEC_BASE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win.valid && (r_in_service == '0)) begin
                        r_state   <= ST_REQ;
                        r_win     <= w_win.idx;
                        r_int_req <= 1'b1;
                        r_vector  <= w_vec;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        r_in_service <= r_in_service | w_win_oh;
                        r_int_req    <= 1'b0;
                        r_state      <= ST_SERVICE;
                    end else if (w_mask_drop) begin
                        r_int_req <= 1'b0;
                        r_state   <= (r_in_service == '0) ? ST_IDLE : ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
`ifdef IRQ_NESTING_EN
                    // iret retires the highest-priority active level first.
                    if (iret) begin
                        r_in_service <= w_isr_rest;
                        if (w_isr_rest == '0) begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_preempt) begin
                        r_state   <= ST_REQ;
                        r_win     <= w_win.idx;
                        r_int_req <= 1'b1;
                        r_vector  <= w_vec;
                    end
`else
                    if (iret) begin
                        r_in_service <= '0;
                        r_state      <= ST_IDLE;
                    end
`endif
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_int_req <= 1'b0;
                end
            endcase
        end
    end

    assign int_req    = r_int_req;
    assign vector     = r_vector;
    assign in_service = r_in_service;
    assign pending    = w_pending;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised interrupt controller between external interrupt lines and the control unit of the 4-bit von Neumann processor.
- Replaces the raw 2-bit irq input with IRQ_N edge-latched, maskable, fixed-priority channels.
- Drives a request/acknowledge handshake and a vector address that the control unit loads into the program counter.
- The control unit pushes the return address to the stack.

Parameters:
- IRQ_N, 4, number of interrupt channels (1..8).
- ADDR_W, 8, width of vector address, equal to the program counter width.
- VEC_BASE, 8'hF0, address of the channel 0 handler.
- VEC_STRIDE, 2, address distance between consecutive channel handlers.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- irq  input  IRQ_N  interrupt lines, already synchronous to clk; a rising edge latches pending.
- mask_we  input  1  one-cycle strobe that writes the mask register.
- mask_din  input  IRQ_N  new mask value; 1 means the channel is enabled.
- int_req  output  1  request to the control unit.
- int_ack  input  1  one-cycle acknowledge from the control unit.
- vector  output  ADDR_W  handler address, valid while int_req is high.
- iret  input  1  one-cycle strobe issued by the control unit on return-from-interrupt.
- in_service  output  IRQ_N  one-hot channel currently being serviced.
- pending  output  IRQ_N  latched pending bits, for debug and status.

Behaviour:
- Reset values:
  - pending = 0, mask = 0 (all channels disabled), in_service = 0.
  - int_req = 0, vector = VEC_BASE, previous-irq register = 0, FSM = IDLE.
- Edge detect: pending[i] sets when irq[i] = 1 and prev[i] = 0. Latching is independent of mask; a masked channel stays pending and is serviced once unmasked.
- Winner: lowest index among (pending & mask). Selection is combinational; int_req and vector are registered.
- FSM IDLE:
  - If any (pending & mask) bit is set and in_service = 0: go to REQ.
  - On that edge, register winner index w and set int_req = 1.
  - vector = VEC_BASE + w*VEC_STRIDE, computed modulo 2^ADDR_W (wraps).
- FSM REQ:
  - Hold int_req and vector stable until int_ack.
  - Re-arbitration is frozen, so a higher channel arriving now waits.
  - On int_ack: clear pending[w], set in_service[w], int_req = 0, go to SERVICE.
  - Latency: irq edge to int_req high is 2 cycles (edge-detect register, then FSM register).
- Masking in REQ: if mask_we clears mask[w] before int_ack, drop int_req and return to IDLE. pending[w] is retained.
- FSM SERVICE:
  - New requests are held pending.
  - On iret: clear in_service and go to IDLE.
  - iret outside SERVICE is ignored.
- Simultaneous events:
  - A new edge on channel w in the same cycle that int_ack clears pending[w]: set wins, so pending[w] stays 1.
  - mask_we takes effect on the next cycle's arbitration.
- int_ack outside REQ is ignored.
- Reset asserted mid-handshake: immediate return to reset values; int_req drops asynchronously.

Optional Feature:
- Macro: IRQ_NESTING_EN.
- Defined:
  - In SERVICE, a strictly lower-index enabled pending channel raises a new REQ.
  - in_service becomes a bit set holding all active levels.
  - iret clears the lowest-index set bit.
  - The FSM returns to IDLE only when in_service = 0; otherwise it stays in SERVICE.
  - An equal or lower-priority channel waits.
- Undefined: single-level behaviour exactly as above; in_service is one-hot or zero.

Decomposition:
- Shared package proc_pkg holds:
  - FSM state typedef (IDLE, REQ, SERVICE).
  - Default VEC_BASE and VEC_STRIDE constants.
  - Priority-encoder function returning index and valid flag.
- One sub-module is natural: irq_edge_latch, holding the prev register, edge detect and pending set/clear with set-priority, instantiated once at IRQ_N width.

Test Plan:
- Reset then mask = 4'b1111, pulse irq[2] → int_req high 2 cycles later, vector = 8'hF4; after int_ack: pending[2] = 0, in_service = 4'b0100; after iret: in_service = 0.
- irq[3] and irq[1] rise in the same cycle → vector = 8'hF2 first; after iret the next REQ has vector = 8'hF6.
- mask = 0, pulse irq[0] → no int_req, pending = 4'b0001; then write mask = 4'b0001 → int_req within 2 cycles, vector = 8'hF0.
- In SERVICE for channel 2, pulse irq[0]:
  - Without IRQ_NESTING_EN: int_req stays 0 until iret.
  - With IRQ_NESTING_EN: int_req with vector 8'hF0, and after ack in_service = 4'b0101.
- Hold int_req for channel 1, clear mask[1] via mask_we → int_req drops next cycle and pending[1] stays 1.
- VEC_BASE = 8'hFE, VEC_STRIDE = 2, irq[1] → vector = 8'h00 (wrap); assert reset during REQ → int_req = 0 immediately, all state at reset values.
